// File: rtl/qmult_pipe.sv
// qmult_pipe: pipelined sign-magnitude fixed-point multiplier.
// The unsigned magnitude product is formed in stage 1. The last stage rounds, detects overflow,
// saturates and fixes the sign. Any stages in between only carry the product forward.
// A single advance signal (output empty or being taken) moves every stage at once.
module qmult_pipe #(
  parameter int N      = 32,
  parameter int Q      = 15,
  parameter int STAGES = 2,
  parameter int ROUND  = 0,
  parameter int SAT    = 1,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_multiplicand,
  input  logic [N-1:0]     i_multiplier,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_ovr,
  output logic             o_ovr_sticky,
  input  logic             i_ovr_clr
);

  localparam int PW = 2 * N - 2;

  // Magnitude after truncation, plus the half-LSB when rounding is enabled.
  // One extra bit on top catches the carry out of the rounding add.
  function automatic logic [N-1:0] round_mag(input logic [N-2:0] kept, input logic half);
    logic [N-1:0] inc;
    inc = (ROUND != 0) ? {{(N-1){1'b0}}, half} : '0;
    return {1'b0, kept} + inc;
  endfunction

  // Clamp to the largest magnitude on overflow, otherwise keep the low bits (wrap).
  function automatic logic [N-2:0] sat_mag(input logic [N-2:0] mag, input logic ovf);
    return (ovf && (SAT != 0)) ? {(N-1){1'b1}} : mag;
  endfunction

  logic             adv;
  logic             out_vld_q, out_vld_d;
  logic [N-1:0]     out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_ovr_q, out_ovr_d;
  logic             sticky_q, sticky_d;

  assign adv     = ~out_vld_q | i_ready;
  assign o_ready = adv;

  // ---- stage 1: unsigned magnitude product and raw sign ----
  logic [PW-1:0] prod_s1;
  logic          sgn_s1;
  assign prod_s1 = PW'(i_multiplicand[N-2:0]) * PW'(i_multiplier[N-2:0]);
  assign sgn_s1  = i_multiplicand[N-1] ^ i_multiplier[N-1];

  // What the last stage sees: the combinational product when the pipe is one deep,
  // otherwise the oldest registered product.
  logic [PW-1:0]    fin_prod;
  logic             fin_sgn;
  logic [TAG_W-1:0] fin_tag;
  logic             fin_vld;

  generate
    if (STAGES == 1) begin : g_single
      assign fin_prod = prod_s1;
      assign fin_sgn  = sgn_s1;
      assign fin_tag  = i_tag;
      assign fin_vld  = i_valid;
    end else begin : g_pipe
      localparam int D = STAGES - 1;
      logic [PW-1:0]    prod_q [D];
      logic [PW-1:0]    prod_d [D];
      logic             sgn_q  [D];
      logic             sgn_d  [D];
      logic [TAG_W-1:0] tag_q  [D];
      logic [TAG_W-1:0] tag_d  [D];
      logic             vld_q  [D];
      logic             vld_d  [D];

      // Hold every stage, or shift the whole chain one step when the pipe advances.
      always_comb begin
        for (int k = 0; k < D; k++) begin
          prod_d[k] = prod_q[k];
          sgn_d[k]  = sgn_q[k];
          tag_d[k]  = tag_q[k];
          vld_d[k]  = vld_q[k];
        end
        if (adv) begin
          prod_d[0] = prod_s1;
          sgn_d[0]  = sgn_s1;
          tag_d[0]  = i_tag;
          vld_d[0]  = i_valid;
          for (int k = 1; k < D; k++) begin
            prod_d[k] = prod_q[k-1];
            sgn_d[k]  = sgn_q[k-1];
            tag_d[k]  = tag_q[k-1];
            vld_d[k]  = vld_q[k-1];
          end
        end
      end

      // Stage valid bits: reset drops every in-flight beat.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int k = 0; k < D; k++) vld_q[k] <= 1'b0;
        end else begin
          for (int k = 0; k < D; k++) vld_q[k] <= vld_d[k];
        end
      end

      // Stage data: meaningless while the matching valid is low, so no reset.
      always_ff @(posedge i_clk) begin
        for (int k = 0; k < D; k++) begin
          prod_q[k] <= prod_d[k];
          sgn_q[k]  <= sgn_d[k];
          tag_q[k]  <= tag_d[k];
        end
      end

      assign fin_prod = prod_q[D-1];
      assign fin_sgn  = sgn_q[D-1];
      assign fin_tag  = tag_q[D-1];
      assign fin_vld  = vld_q[D-1];
    end
  endgenerate

  // ---- last stage: round, overflow, saturate, sign fix-up ----
  logic [N-1:0] fin_m;
  logic         fin_ovf;
  logic [N-2:0] fin_mag;
  logic         unused_lsbs;

  assign fin_m       = round_mag(fin_prod[N-2+Q:Q], fin_prod[Q-1]);
  assign fin_ovf     = (|fin_prod[PW-1:N-1+Q]) | fin_m[N-1];
  assign fin_mag     = sat_mag(fin_m[N-2:0], fin_ovf);
  assign unused_lsbs = ^fin_prod[Q-1:0];

  // Output register loads on advance; sticky flag lets a new overflow win over a clear.
  always_comb begin
    out_vld_d = out_vld_q;
    out_res_d = out_res_q;
    out_tag_d = out_tag_q;
    out_ovr_d = out_ovr_q;
    if (adv) begin
      out_vld_d = fin_vld;
      out_res_d = {fin_sgn & (fin_mag != '0), fin_mag};
      out_tag_d = fin_tag;
      out_ovr_d = fin_ovf;
    end
    sticky_d = (out_vld_q & i_ready & out_ovr_q) | (sticky_q & ~i_ovr_clr);
  end

  // Output and sticky state, all cleared by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_vld_q <= 1'b0;
      out_res_q <= '0;
      out_tag_q <= '0;
      out_ovr_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      out_res_q <= out_res_d;
      out_tag_q <= out_tag_d;
      out_ovr_q <= out_ovr_d;
      sticky_q  <= sticky_d;
    end
  end

  assign o_valid      = out_vld_q;
  assign o_result     = out_res_q;
  assign o_tag        = out_tag_q;
  assign o_ovr        = out_ovr_q;
  assign o_ovr_sticky = sticky_q;

endmodule
